// File: rtl/regfile_tag.sv
// regfile_tag: 32x32 integer register file with a per-register rename tag
// and a pending-write counter. x0 carries no state and always reads as zero.
// Writeback data lands only when its tag matches the register's current
// (youngest) tag; older writers just retire their pending count.
module regfile_tag #(
    parameter int TAG_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rd_rf1_en,
    input  logic [4:0]           rd_rf1_addr,
    output logic [31:0]          rd_rf1_data,
    output logic [TAG_WIDTH-1:0] rd_rf1_tag,
    output logic                 rd_rf1_dirty,
    input  logic                 rd_rf2_en,
    input  logic [4:0]           rd_rf2_addr,
    output logic [31:0]          rd_rf2_data,
    output logic [TAG_WIDTH-1:0] rd_rf2_tag,
    output logic                 rd_rf2_dirty,
    input  logic                 alloc_en,
    input  logic [4:0]           alloc_addr,
    output logic [TAG_WIDTH-1:0] alloc_tag,
    output logic                 alloc_stall,
    input  logic                 wb_en,
    input  logic [4:0]           wb_addr,
    input  logic [TAG_WIDTH-1:0] wb_tag,
    input  logic [31:0]          wb_data,
    input  logic                 flush
);

    localparam logic [TAG_WIDTH-1:0] CNT_MAX = {TAG_WIDTH{1'b1}};

    // Flat views of the per-register state; entry 0 is tied to zero so
    // every lookup indexed by a 5-bit address is naturally x0-safe.
    logic [31:0]          data_arr [0:31];
    logic [TAG_WIDTH-1:0] tag_arr  [0:31];
    logic [TAG_WIDTH-1:0] cnt_arr  [0:31];

    assign data_arr[0] = '0;
    assign tag_arr[0]  = '0;
    assign cnt_arr[0]  = '0;

    logic [TAG_WIDTH-1:0] wb_cnt;

    assign alloc_tag   = tag_arr[alloc_addr] + 1'b1;
    assign alloc_stall = alloc_en && (alloc_addr != 5'd0) && (cnt_arr[alloc_addr] == CNT_MAX);
    assign wb_cnt      = cnt_arr[wb_addr];

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi = gi + 1) begin : g_reg
            logic [31:0]          data_reg;
            logic [TAG_WIDTH-1:0] tag_reg;
            logic [TAG_WIDTH-1:0] cnt_reg;
            logic                 alloc_acc;
            logic                 wb_acc;

            // A flush drops any concurrent allocation outright.
            assign alloc_acc = alloc_en && (alloc_addr == 5'(gi)) && !alloc_stall && !flush;
            assign wb_acc    = wb_en && (wb_addr == 5'(gi)) && (cnt_reg != '0);

            // Per-register state update: data on matching-tag writeback,
            // tag advance on alloc, counter tracks in-flight writers.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_reg <= '0;
                    tag_reg  <= '0;
                    cnt_reg  <= '0;
                end else begin
                    if (wb_acc && (wb_tag == tag_reg)) begin
                        data_reg <= wb_data;
                    end
                    if (flush) begin
                        cnt_reg <= '0;
                    end else if (alloc_acc && !wb_acc) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end else if (!alloc_acc && wb_acc) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                    if (alloc_acc) begin
                        tag_reg <= tag_reg + 1'b1;
                    end
                end
            end

            assign data_arr[gi] = data_reg;
            assign tag_arr[gi]  = tag_reg;
            assign cnt_arr[gi]  = cnt_reg;
        end
    endgenerate

    // Read ports come from registered state only; the scoreboard handles
    // any writeback bypass.
    always_comb begin
        rd_rf1_data  = '0;
        rd_rf1_tag   = '0;
        rd_rf1_dirty = 1'b0;
        if (rd_rf1_en && (rd_rf1_addr != 5'd0)) begin
            rd_rf1_data  = data_arr[rd_rf1_addr];
            rd_rf1_tag   = tag_arr[rd_rf1_addr];
            rd_rf1_dirty = (cnt_arr[rd_rf1_addr] != '0);
        end
    end

    // Second read port, identical to the first.
    always_comb begin
        rd_rf2_data  = '0;
        rd_rf2_tag   = '0;
        rd_rf2_dirty = 1'b0;
        if (rd_rf2_en && (rd_rf2_addr != 5'd0)) begin
            rd_rf2_data  = data_arr[rd_rf2_addr];
            rd_rf2_tag   = tag_arr[rd_rf2_addr];
            rd_rf2_dirty = (cnt_arr[rd_rf2_addr] != '0);
        end
    end

    // A writeback with nothing pending means the pipeline lost track of a writer.
    wb_without_pending : assert property (@(posedge clk) disable iff (!rst_n)
        !(wb_en && (wb_addr != 5'd0) && (wb_cnt == '0)));

endmodule

// File: tb/tb_regfile_tag.sv
// Directed testbench for regfile_tag: linear steps with hand-computed
// expectations, one line printed per transaction.
module tb_regfile_tag;

    logic        clk;
    logic        rst_n;
    logic        rd_rf1_en;
    logic [4:0]  rd_rf1_addr;
    logic [31:0] rd_rf1_data;
    logic [1:0]  rd_rf1_tag;
    logic        rd_rf1_dirty;
    logic        rd_rf2_en;
    logic [4:0]  rd_rf2_addr;
    logic [31:0] rd_rf2_data;
    logic [1:0]  rd_rf2_tag;
    logic        rd_rf2_dirty;
    logic        alloc_en;
    logic [4:0]  alloc_addr;
    logic [1:0]  alloc_tag;
    logic        alloc_stall;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [1:0]  wb_tag;
    logic [31:0] wb_data;
    logic        flush;

    int checks;
    int failures;

    regfile_tag #(.TAG_WIDTH(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_rf1_en   (rd_rf1_en),
        .rd_rf1_addr (rd_rf1_addr),
        .rd_rf1_data (rd_rf1_data),
        .rd_rf1_tag  (rd_rf1_tag),
        .rd_rf1_dirty(rd_rf1_dirty),
        .rd_rf2_en   (rd_rf2_en),
        .rd_rf2_addr (rd_rf2_addr),
        .rd_rf2_data (rd_rf2_data),
        .rd_rf2_tag  (rd_rf2_tag),
        .rd_rf2_dirty(rd_rf2_dirty),
        .alloc_en    (alloc_en),
        .alloc_addr  (alloc_addr),
        .alloc_tag   (alloc_tag),
        .alloc_stall (alloc_stall),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_tag      (wb_tag),
        .wb_data     (wb_data),
        .flush       (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rd1(input logic [4:0] a);
        rd_rf1_en = 1'b1;
        rd_rf1_addr = a;
        #1;
    endtask

    task automatic rd2(input logic [4:0] a);
        rd_rf2_en = 1'b1;
        rd_rf2_addr = a;
        #1;
    endtask

    task automatic do_alloc(input logic [4:0] a);
        alloc_en = 1'b1;
        alloc_addr = a;
        #1;
        $display("alloc x%0d tag=%0d stall=%0b", a, alloc_tag, alloc_stall);
    endtask

    task automatic do_wb(input logic [4:0] a, input logic [1:0] t, input logic [31:0] d);
        wb_en = 1'b1;
        wb_addr = a;
        wb_tag = t;
        wb_data = d;
        $display("wb x%0d tag=%0d data=%h", a, t, d);
    endtask

    task automatic idle;
        alloc_en = 1'b0;
        alloc_addr = '0;
        wb_en = 1'b0;
        wb_addr = '0;
        wb_tag = '0;
        wb_data = '0;
        flush = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        rd_rf1_en = 1'b0;
        rd_rf1_addr = '0;
        rd_rf2_en = 1'b0;
        rd_rf2_addr = '0;
        idle();

        // Reset state
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        rd1(5'd5);
        rd2(5'd0);
        $display("read after reset x5/x0");
        check("rst_x5_data", rd_rf1_data, 32'h0);
        check("rst_x5_tag", 32'(rd_rf1_tag), 32'd0);
        check("rst_x5_dirty", 32'(rd_rf1_dirty), 32'd0);
        check("rst_x0_data", rd_rf2_data, 32'h0);
        check("rst_x0_dirty", 32'(rd_rf2_dirty), 32'd0);
        rd_rf1_en = 1'b0;
        #1;
        check("en0_data", rd_rf1_data, 32'h0);
        check("en0_dirty", 32'(rd_rf1_dirty), 32'd0);

        // Single writer to x5
        do_alloc(5'd5);
        check("x5_alloc_tag", 32'(alloc_tag), 32'd1);
        check("x5_alloc_stall", 32'(alloc_stall), 32'd0);
        tick();
        idle();
        rd1(5'd5);
        check("x5_pend_dirty", 32'(rd_rf1_dirty), 32'd1);
        check("x5_pend_tag", 32'(rd_rf1_tag), 32'd1);
        do_wb(5'd5, 2'd1, 32'hDEADBEEF);
        tick();
        idle();
        #1;
        check("x5_wb_data", rd_rf1_data, 32'hDEADBEEF);
        check("x5_wb_dirty", 32'(rd_rf1_dirty), 32'd0);

        // Two writers to x7
        do_alloc(5'd7);
        check("x7_alloc1_tag", 32'(alloc_tag), 32'd1);
        tick();
        do_alloc(5'd7);
        check("x7_alloc2_tag", 32'(alloc_tag), 32'd2);
        tick();
        idle();
        do_wb(5'd7, 2'd1, 32'h11);
        tick();
        idle();
        rd1(5'd7);
        check("x7_stale_data", rd_rf1_data, 32'h0);
        check("x7_stale_dirty", 32'(rd_rf1_dirty), 32'd1);
        do_wb(5'd7, 2'd2, 32'h22);
        tick();
        idle();
        #1;
        check("x7_young_data", rd_rf1_data, 32'h22);
        check("x7_young_dirty", 32'(rd_rf1_dirty), 32'd0);

        // Saturation on x3
        do_alloc(5'd3); tick();
        do_alloc(5'd3); tick();
        do_alloc(5'd3); tick();
        do_alloc(5'd3);
        check("x3_sat_stall", 32'(alloc_stall), 32'd1);
        tick();
        rd1(5'd3);
        check("x3_sat_tag", 32'(rd_rf1_tag), 32'd3);
        check("x3_sat_stall_held", 32'(alloc_stall), 32'd1);
        idle();
        do_wb(5'd3, 2'd3, 32'h33);
        tick();
        idle();
        do_alloc(5'd3);
        check("x3_unstall", 32'(alloc_stall), 32'd0);
        check("x3_wrap_tag", 32'(alloc_tag), 32'd0);
        tick();
        idle();
        #1;
        check("x3_wrap_rd_tag", 32'(rd_rf1_tag), 32'd0);
        check("x3_wrap_dirty", 32'(rd_rf1_dirty), 32'd1);
        check("x3_wb_data", rd_rf1_data, 32'h33);

        // Same-cycle alloc and wb on x9
        do_alloc(5'd9);
        tick();
        do_alloc(5'd9);
        check("x9_alloc2_tag", 32'(alloc_tag), 32'd2);
        do_wb(5'd9, 2'd1, 32'hA5);
        tick();
        idle();
        rd1(5'd9);
        check("x9_same_data", rd_rf1_data, 32'hA5);
        check("x9_same_dirty", 32'(rd_rf1_dirty), 32'd1);
        check("x9_same_tag", 32'(rd_rf1_tag), 32'd2);
        do_wb(5'd9, 2'd2, 32'h5A);
        tick();
        idle();
        #1;
        check("x9_cnt1_data", rd_rf1_data, 32'h5A);
        check("x9_cnt1_dirty", 32'(rd_rf1_dirty), 32'd0);

        // Flush with pending writers on x4 and x6
        do_alloc(5'd4); tick();
        do_alloc(5'd6); tick();
        idle();
        rd1(5'd4);
        rd2(5'd6);
        check("x4_pre_dirty", 32'(rd_rf1_dirty), 32'd1);
        check("x6_pre_dirty", 32'(rd_rf2_dirty), 32'd1);
        flush = 1'b1;
        do_alloc(5'd6);
        do_wb(5'd4, 2'd1, 32'h44);
        $display("flush");
        tick();
        idle();
        #1;
        check("x4_flush_dirty", 32'(rd_rf1_dirty), 32'd0);
        check("x4_flush_data", rd_rf1_data, 32'h44);
        check("x6_flush_dirty", 32'(rd_rf2_dirty), 32'd0);
        check("x6_flush_tag", 32'(rd_rf2_tag), 32'd1);
        check("x6_flush_data", rd_rf2_data, 32'h0);
        rd1(5'd3);
        check("x3_flush_dirty", 32'(rd_rf1_dirty), 32'd0);
        check("x3_flush_tag", 32'(rd_rf1_tag), 32'd0);

        // Writes to x0
        do_alloc(5'd0);
        check("x0_alloc_stall", 32'(alloc_stall), 32'd0);
        tick();
        idle();
        rd1(5'd0);
        check("x0_tag", 32'(rd_rf1_tag), 32'd0);
        check("x0_dirty", 32'(rd_rf1_dirty), 32'd0);
        do_wb(5'd0, 2'd0, 32'hFFFFFFFF);
        tick();
        idle();
        #1;
        check("x0_data", rd_rf1_data, 32'h0);
        rd2(5'd5);
        check("x5_retained", rd_rf2_data, 32'hDEADBEEF);

        // Asynchronous reset mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset");
        check("arst_x5_data", rd_rf2_data, 32'h0);
        rd1(5'd9);
        check("arst_x9_tag", 32'(rd_rf1_tag), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
